// File: rtl/clock_set_controller_pkg.sv
// Shared limits, state encoding and field codes for the clock-set controller.
package clock_set_controller_pkg;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_M = 3'd2,
    ST_EDIT_S = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FLD_NONE = 2'd0,
    FLD_HOUR = 2'd1,
    FLD_MIN  = 2'd2,
    FLD_SEC  = 2'd3
  } field_e;

  function automatic logic is_edit(input state_e s);
    return (s == ST_EDIT_H) || (s == ST_EDIT_M) || (s == ST_EDIT_S);
  endfunction

  function automatic field_e field_of(input state_e s);
    case (s)
      ST_EDIT_H: return FLD_HOUR;
      ST_EDIT_M: return FLD_MIN;
      ST_EDIT_S: return FLD_SEC;
      default:   return FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_controller_mod_step.sv
// Modular +1/-1 step of a 0..max field; simultaneous inc and dec leave it unchanged.
module mod_step #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] max_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] next_o
);

  always_comb begin
    next_o = value_i;
    if (inc_i && !dec_i) begin
      next_o = (value_i == max_i) ? '0 : value_i + 1'b1;
    end else if (dec_i && !inc_i) begin
      next_o = (value_i == '0) ? max_i : value_i - 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Time-setting FSM: captures live time, edits h/m/s with wrap, and issues a load pulse on commit.
module clock_set_controller
  import clock_set_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned BLINK_HALF     = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic       editing,
  output logic [1:0] field_sel,
  output logic       blink
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF - 1);

  state_e          state_q, state_d;
  logic [4:0]      hour_q, hour_d, hour_step;
  logic [5:0]      min_q, min_d, min_step;
  logic [5:0]      sec_q, sec_d, sec_step;
  logic [TW-1:0]   to_q, to_d;
  logic [BW-1:0]   bl_cnt_q, bl_cnt_d;
  logic            blink_q, blink_d;
  logic            load_q, editing_q;
  logic [1:0]      field_sel_q;

  logic any_btn, step_inc, step_dec;

  assign any_btn  = btn_mode | btn_inc | btn_dec;
  // A mode press in the same cycle discards inc/dec.
  assign step_inc = btn_inc & ~btn_mode;
  assign step_dec = btn_dec & ~btn_mode;

  mod_step #(.W(5)) u_hour (
    .value_i (hour_q),
    .max_i   (HOUR_MAX),
    .inc_i   (step_inc & (state_q == ST_EDIT_H)),
    .dec_i   (step_dec & (state_q == ST_EDIT_H)),
    .next_o  (hour_step)
  );

  mod_step #(.W(6)) u_min (
    .value_i (min_q),
    .max_i   (MIN_MAX),
    .inc_i   (step_inc & (state_q == ST_EDIT_M)),
    .dec_i   (step_dec & (state_q == ST_EDIT_M)),
    .next_o  (min_step)
  );

  mod_step #(.W(6)) u_sec (
    .value_i (sec_q),
    .max_i   (SEC_MAX),
    .inc_i   (step_inc & (state_q == ST_EDIT_S)),
    .dec_i   (step_dec & (state_q == ST_EDIT_S)),
    .next_o  (sec_step)
  );

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    to_d    = to_q;

    case (state_q)
      ST_IDLE: begin
        to_d = '0;
        if (btn_mode) begin
          state_d = ST_EDIT_H;
          hour_d  = cur_hour;
          min_d   = cur_min;
          sec_d   = cur_sec;
        end
      end
      ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
        hour_d = hour_step;
        min_d  = min_step;
        sec_d  = sec_step;
        if (any_btn) begin
          to_d = '0;
        end else if (to_q == TO_LAST) begin
          state_d = ST_IDLE;
          to_d    = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
        if (btn_mode) begin
          case (state_q)
            ST_EDIT_H: state_d = ST_EDIT_M;
            ST_EDIT_M: state_d = ST_EDIT_S;
            default:   state_d = ST_COMMIT;
          endcase
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        to_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
        to_d    = '0;
      end
    endcase
  end

  // Blink phase restarts only when entering edit from outside, not on field advance.
  always_comb begin
    blink_d  = blink_q;
    bl_cnt_d = bl_cnt_q;
    if (is_edit(state_d)) begin
      if (!is_edit(state_q)) begin
        blink_d  = 1'b1;
        bl_cnt_d = '0;
      end else if (bl_cnt_q == BL_LAST) begin
        blink_d  = ~blink_q;
        bl_cnt_d = '0;
      end else begin
        bl_cnt_d = bl_cnt_q + 1'b1;
      end
    end else begin
      blink_d  = 1'b0;
      bl_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      to_q        <= '0;
      bl_cnt_q    <= '0;
      blink_q     <= 1'b0;
      load_q      <= 1'b0;
      editing_q   <= 1'b0;
      field_sel_q <= '0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      to_q        <= to_d;
      bl_cnt_q    <= bl_cnt_d;
      blink_q     <= blink_d;
      load_q      <= (state_q == ST_COMMIT);
      editing_q   <= is_edit(state_d);
      field_sel_q <= field_of(state_d);
    end
  end

  assign set_hour  = hour_q;
  assign set_min   = min_q;
  assign set_sec   = sec_q;
  assign load      = load_q;
  assign editing   = editing_q;
  assign field_sel = field_sel_q;
  assign blink     = blink_q;

endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: idle cycles in any edit state before the edit is abandoned.
REQ-002 Parameter BLINK_HALF, default 250: cycles per half-period of the blink output.
REQ-003 Port clk  input  1  single clock; every register updates on its rising edge.
REQ-004 Port reset_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 Port btn_mode  input  1  single-cycle pulse (debounced upstream); enters edit mode or advances the field.
REQ-006 Port btn_inc  input  1  single-cycle pulse; increments the selected field.
REQ-007 Port btn_dec  input  1  single-cycle pulse; decrements the selected field.
REQ-008 Port cur_hour  input  5  live hour from the clock counters, 0..23.
REQ-009 Port cur_min  input  6  live minute, 0..59.
REQ-010 Port cur_sec  input  6  live second, 0..59.
REQ-011 Port set_hour  output  5  hour value being edited or loaded.
REQ-012 Port set_min  output  6  minute value being edited or loaded.
REQ-013 Port set_sec  output  6  second value being edited or loaded.
REQ-014 Port load  output  1  one-cycle pulse; the counters take set_* when load is 1.
REQ-015 Port editing  output  1  high in EDIT_H, EDIT_M and EDIT_S.
REQ-016 Port field_sel  output  2  selected field: 0 = none, 1 = hour, 2 = minute, 3 = second.
REQ-017 Port blink  output  1  toggles every BLINK_HALF cycles while editing; 0 otherwise.

Function
REQ-018 The FSM SHALL have the states IDLE, EDIT_H, EDIT_M, EDIT_S and COMMIT.
REQ-019 IDLE + btn_mode -> EDIT_H; on that same edge cur_hour, cur_min and cur_sec are captured into set_*.
REQ-020 EDIT_H + btn_mode -> EDIT_M; EDIT_M + btn_mode -> EDIT_S; EDIT_S + btn_mode -> COMMIT.
REQ-021 COMMIT SHALL assert load for exactly one cycle, then go to IDLE unconditionally; buttons are ignored in COMMIT.
REQ-022 set_* SHALL hold stable from the cycle load is asserted until the next capture.
REQ-023 btn_inc alone increments the selected field one cycle after the pulse; hour wraps 23->0, minute and second wrap 59->0.
REQ-024 btn_dec alone decrements the selected field one cycle after the pulse; hour wraps 0->23, minute and second wrap 0->59.
REQ-025 btn_inc and btn_dec in the same cycle cause no change to the field but do reset the timeout counter.
REQ-026 btn_mode in the same cycle as btn_inc or btn_dec: the field advance wins and the inc/dec is discarded.
REQ-027 btn_inc and btn_dec in IDLE SHALL be ignored.
REQ-028 The timeout counter clears on any button pulse and on entry to an edit state.
REQ-029 When the timeout counter reaches TIMEOUT_CYCLES-1 in an edit state, the FSM goes to IDLE with no load pulse; set_* keep their values.
REQ-030 If a button pulse and timeout expiry occur in the same cycle, the button wins.
REQ-031 The timeout counter width is clog2(TIMEOUT_CYCLES); the blink counter width is clog2(BLINK_HALF).
REQ-032 blink starts at 1 on entry to EDIT_H; it is not restarted on the EDIT_M and EDIT_S transitions.
REQ-033 editing and field_sel SHALL be registered outputs that decode the current state.

Reset
REQ-034 While reset_n is 0 at a clk edge: state = IDLE, set_* = 0, load = 0, editing = 0, field_sel = 0, blink = 0, and both counters = 0.
REQ-035 Reset asserted during edit or COMMIT aborts the operation, and no load pulse is produced on or after that edge.

Structure
REQ-036 A shared package SHALL hold HOUR_MAX = 23, MIN_MAX = 59, SEC_MAX = 59 and the state encoding.
REQ-037 A sub-module mod_step SHALL implement the modular increment/decrement; it takes value, max, inc and dec and is instantiated once per field.
REQ-038 The block SHALL contain no combinational path from the btn_* inputs to any output.

Verification
REQ-039 Reset, then cur = 12:34:56, pulse mode -> next cycle set = 12:34:56, field_sel = 1, editing = 1.
REQ-040 In EDIT_H with hour 23, pulse inc -> hour 0; in EDIT_M with minute 0, pulse dec -> minute 59.
REQ-041 Pulse mode x4 from IDLE with inc x2 in EDIT_S starting at sec 58 -> sec 0, load high for exactly 1 cycle with set = hh:mm:00.
REQ-042 Enter EDIT_M, no buttons for TIMEOUT_CYCLES cycles -> state IDLE, load never asserted; an inc at cycle TIMEOUT_CYCLES-1 instead keeps the FSM in EDIT_M.
REQ-043 inc+dec in the same cycle -> field unchanged; mode+inc in the same cycle -> field advances and the value is unchanged.
REQ-044 reset_n low in the cycle the FSM is in COMMIT -> load stays 0 and all outputs equal their reset values.
